clkdiv_prog: RTL
================

# clkdiv_prog

Multi-channel, runtime-programmable clock-enable divider generalising the fixed-divisor divider. Each of CHANNELS outputs divides clk_in by its own integer divisor. Divisors are written at run time and take effect glitch-free at the channel's next period boundary. Supports odd divisors, per-channel enable with period-complete stop, and a global phase-align restart; sits between the system clock and slow peripheral strobes (relay drivers, scan timers).

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- CNT_W, 16, counter/divisor width in bits
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be >= 2)
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high; clock clk_in
- div_wr  input  1  divisor write strobe, sampled on rising clk_in
- div_ch  input  4  target channel of write; values >= CHANNELS ignored
- div_val  input  CNT_W  new divisor; values 0 and 1 clamped to 2
- en  input  CHANNELS  per-channel run enable, level
- sync  input  1  one-cycle pulse: restart all enabled channels in phase
- clk_out  output  CHANNELS  divided outputs, registered
- tick  output  CHANNELS  one-cycle pulse coincident with each clk_out rising edge
- running  output  CHANNELS  channel is actively dividing

## Operation
- Per channel state: pend_div (written value), act_div (value in use), cnt[CNT_W-1:0], run flag; hi = act_div >> 1 (floor).
- Write: on edge with div_wr=1 and div_ch<CHANNELS, pend_div[div_ch] <= max(div_val,2). Writes to other channels unaffected.
- Stopped (run=0): clk_out=0, tick=0, cnt=0. On edge with en=1: run<=1, cnt<=0, act_div<=pend_div, clk_out<=1, tick<=1.
- Running, cnt == act_div-1 (period boundary): if en=1: cnt<=0, act_div<=pend_div, clk_out<=1, tick<=1. If en=0: run<=0, cnt<=0, clk_out<=0 (disable completes the current period; never truncates a high phase).
- Running, otherwise: cnt<=cnt+1, clk_out<=((cnt+1) < hi), tick<=0.
- Waveform per period of N cycles: high for floor(N/2), low for N-floor(N/2). N=2: 1/1; N=5: 1,1,0,0,0.
- sync=1 (priority over boundary/enable logic, below reset): every channel with en=1 does cnt<=0, act_div<=pend_div, clk_out<=1, tick<=1, run<=1; channels with en=0 and run=1 also stop immediately (clk_out<=0, run<=0). The current period may be shortened.
- running = run flag.

## Timing
- Reset (async): clk_out=0, tick=0, running=0, cnt=0, pend_div=act_div=DEFAULT_DIV for all channels.
- Start latency: en sampled high at edge k -> clk_out/tick high after edge k.
- Divisor change: a write at edge k is visible at the first boundary strictly after edge k; a write at the same edge as a boundary is not used at that boundary.
- Back-to-back writes to one channel before a boundary: last value wins.
- en deasserted mid-period: output continues unchanged to the boundary, then stops; re-asserted before the boundary: no effect on waveform.
- Wrap-around: cnt never exceeds act_div-1; act_div = 2^CNT_W-1 supported without overflow.
- Reset mid-period forces outputs low immediately, without waiting for clk_in.

## Test plan
- Reset release, en=4'b0001, default div 2 -> clk_out[0] toggles 1,0,1,0 from edge after en; tick[0] every 2 cycles; other channels 0.
- Write ch1 div_val=5, en[1]=1 -> clk_out[1] pattern 1,1,0,0,0 repeating; tick[1] every 5 cycles.
- Ch0 running at 4, write 7 mid-period -> current period completes at 4 cycles, next period 7 cycles (3 high, 4 low), no runt pulse.
- div_val=0 and 1 to ch2 -> behaves as divisor 2; write with div_ch=9 -> no channel changes.
- Ch0 div 3, ch1 div 6 running out of phase, pulse sync -> both clk_out and tick high on the next cycle simultaneously, then periods 3 and 6.
- Drop en[0] during high phase of div 8 -> finishes 8-cycle period, running[0]=0; assert reset mid-period on ch1 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock-enable divider. Each channel divides clk_in
// by its own run-time divisor, switching divisors only at period boundaries.
module clkdiv_prog #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                div_wr,
    input  logic [3:0]          div_ch,
    input  logic [CNT_W-1:0]    div_val,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] running
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Divisors below 2 cannot produce a high and a low phase.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           st, st_nxt;
        logic [CNT_W-1:0] pend_div, pend_nxt;
        logic [CNT_W-1:0] act_div, act_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] hi;
        logic             out_q, out_nxt;
        logic             tick_q, tick_nxt;
        logic             wr_hit;
        logic             boundary;

        // div_ch values >= CHANNELS match no generated channel and are dropped.
        assign wr_hit   = div_wr && (div_ch == 4'(c));
        assign boundary = (cnt == act_div - CNT_W'(1));
        assign cnt_inc  = cnt + CNT_W'(1);
        assign hi       = act_div >> 1;

        always_comb begin
            st_nxt   = st;
            pend_nxt = wr_hit ? clamp_div(div_val) : pend_div;
            act_nxt  = act_div;
            cnt_nxt  = cnt;
            out_nxt  = 1'b0;
            tick_nxt = 1'b0;

            if (sync) begin
                // Phase-align restart overrides boundary and enable handling.
                cnt_nxt = '0;
                if (en[c]) begin
                    st_nxt   = ST_RUN;
                    act_nxt  = pend_div;
                    out_nxt  = 1'b1;
                    tick_nxt = 1'b1;
                end else begin
                    st_nxt = ST_IDLE;
                end
            end else begin
                case (st)
                    ST_IDLE: begin
                        cnt_nxt = '0;
                        if (en[c]) begin
                            st_nxt   = ST_RUN;
                            act_nxt  = pend_div;
                            out_nxt  = 1'b1;
                            tick_nxt = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (boundary) begin
                            cnt_nxt = '0;
                            if (en[c]) begin
                                act_nxt  = pend_div;
                                out_nxt  = 1'b1;
                                tick_nxt = 1'b1;
                            end else begin
                                st_nxt = ST_IDLE;
                            end
                        end else begin
                            // Not at boundary, so cnt_inc <= act_div-1 and cannot wrap.
                            cnt_nxt = cnt_inc;
                            out_nxt = (cnt_inc < hi);
                        end
                    end
                    default: begin
                        st_nxt  = ST_IDLE;
                        cnt_nxt = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                st       <= ST_IDLE;
                pend_div <= DEF_DIV;
                act_div  <= DEF_DIV;
                cnt      <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                st       <= st_nxt;
                pend_div <= pend_nxt;
                act_div  <= act_nxt;
                cnt      <= cnt_nxt;
                out_q    <= out_nxt;
                tick_q   <= tick_nxt;
            end
        end

        assign clk_out[c] = out_q;
        assign tick[c]    = tick_q;
        assign running[c] = (st == ST_RUN);
    end

endmodule
